// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between the data and instruction
// request slots of CPUS cache ports; one access outstanding at a time.
module mem_arbiter #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  localparam int NS  = 2 * CPUS,
  localparam int SW  = $clog2(NS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS-1:0][AW-1:0]  iaddr,
  input  logic [CPUS-1:0][AW-1:0]  daddr,
  input  logic [CPUS-1:0][DW-1:0]  dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS-1:0][DW-1:0]  iload,
  output logic [CPUS-1:0][DW-1:0]  dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [AW-1:0]            ramaddr,
  output logic [DW-1:0]            ramstore,
  input  logic [DW-1:0]            ramload,
  input  logic [1:0]               ramstate,
  output logic                     dbg_state_o,
  output logic [SW-1:0]            dbg_gnt_o,
  output logic [SW-1:0]            dbg_ptr_o
);

  localparam int CW = (SW > 1) ? SW - 1 : 1;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e        state_q;
  logic [SW-1:0] gnt_q;
  logic [SW-1:0] ptr_q;

  logic [NS-1:0] req;
  logic [SW-1:0] sel;
  logic [SW-1:0] idx;
  logic          found;
  logic [CW-1:0] gk;
  logic          gnt_is_i;
  logic          gnt_req;
  logic          live;
  logic [SW-1:0] ptr_inc;

  // Slot 2k is the data port of CPU k, slot 2k+1 its instruction port.
  always_comb begin
    req = '0;
    for (int k = 0; k < CPUS; k++) begin
      req[2*k]   = dREN[k] | dWEN[k];
      req[2*k+1] = iREN[k];
    end
  end

  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NS; off++) begin
      idx = SW'((int'(ptr_q) + off) % NS);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign gk       = CW'(gnt_q >> 1);
  assign gnt_is_i = gnt_q[0];
  assign gnt_req  = req[gnt_q];
  assign live     = (state_q == S_BUSY) && gnt_req;
  assign ptr_inc  = (gnt_q == SW'(NS - 1)) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gnt_q   <= sel;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A dropped request releases the RAM without advancing fairness.
          if (!gnt_req) begin
            state_q <= S_IDLE;
          end else if (ramstate == RS_ACCESS || ramstate == RS_ERROR) begin
            state_q <= S_IDLE;
            ptr_q   <= ptr_inc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (live) begin
      if (gnt_is_i) begin
        ramaddr = iaddr[gk];
        ramREN  = 1'b1;
      end else begin
        ramaddr  = daddr[gk];
        ramstore = dstore[gk];
        if (dREN[gk]) ramREN = 1'b1;
        else          ramWEN = 1'b1;
      end
      if (ramstate == RS_ACCESS) begin
        if (gnt_is_i) iwait[gk] = 1'b0;
        else          dwait[gk] = 1'b0;
      end
    end
  end

  always_comb begin
    iload = '0;
    dload = '0;
    for (int k = 0; k < CPUS; k++) begin
      iload[k] = ramload;
      dload[k] = ramload;
    end
  end

  assign dbg_state_o = (state_q == S_BUSY);
  assign dbg_gnt_o   = gnt_q;
  assign dbg_ptr_o   = ptr_q;

endmodule
